// File: rtl/wisc_pkg.sv
// Shared ISA definitions for the WISC-S25 single-cycle core: opcodes,
// branch condition codes, flag bit positions and the branch-condition helper.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL    = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW     = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B      = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NE = 3'b000, CC_EQ = 3'b001, CC_GT = 3'b010, CC_LT = 3'b011,
    CC_GE = 3'b100, CC_LE = 3'b101, CC_OV = 3'b110, CC_UN = 3'b111
  } ccode_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic cond_met(input ccode_e cc, input logic [2:0] flags);
    logic z, v, n;
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    case (cc)
      CC_NE:   cond_met = ~z;
      CC_EQ:   cond_met = z;
      CC_GT:   cond_met = ~z & ~n;
      CC_LT:   cond_met = n;
      CC_GE:   cond_met = z | (~z & ~n);
      CC_LE:   cond_met = z | n;
      CC_OV:   cond_met = v;
      CC_UN:   cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wisc_alu.sv
// Datapath ALU: saturating add/sub, XOR, RED, shifts/rotate, PADDSB,
// memory address generation and the LLB/LHB byte merge, plus Z/N/V results.
module wisc_alu
  import wisc_pkg::*;
(
  input  opcode_e     op,
  input  logic [15:0] Input_A,
  input  logic [15:0] Input_B,
  output logic [15:0] ALU_Out,
  output logic        Z_set,
  output logic        N_set,
  output logic        V_set
);

  logic [15:0] b_eff;
  logic [15:0] sum;
  logic [15:0] red;
  logic [15:0] rot;
  logic        ovf;
  logic [4:0]  nib;

  always_comb begin
    b_eff = (op == OP_SUB) ? ~Input_B : Input_B;
    sum   = Input_A + b_eff + {15'd0, op == OP_SUB};
    ovf   = (Input_A[15] == b_eff[15]) && (sum[15] != Input_A[15]);
    red   = {{8{Input_A[15]}}, Input_A[15:8]} + {{8{Input_B[15]}}, Input_B[15:8]}
          + {{8{Input_A[7]}},  Input_A[7:0]}  + {{8{Input_B[7]}},  Input_B[7:0]};
    rot   = 16'({Input_A, Input_A} >> Input_B[3:0]);
    nib   = 5'd0;
    ALU_Out = Input_A + Input_B;
    case (op)
      OP_ADD, OP_SUB: ALU_Out = ovf ? (Input_A[15] ? 16'h8000 : 16'h7FFF) : sum;
      OP_XOR:         ALU_Out = Input_A ^ Input_B;
      OP_RED:         ALU_Out = red;
      OP_SLL:         ALU_Out = Input_A << Input_B[3:0];
      OP_SRA:         ALU_Out = $signed(Input_A) >>> Input_B[3:0];
      OP_ROR:         ALU_Out = rot;
      OP_PADDSB: begin
        // A nibble overflowed when the 5-bit sign extension disagrees with bit 3
        for (int i = 0; i < 4; i++) begin
          nib = {Input_A[4*i+3], Input_A[4*i +: 4]} + {Input_B[4*i+3], Input_B[4*i +: 4]};
          ALU_Out[4*i +: 4] = (nib[4] != nib[3]) ? {nib[4], {3{~nib[4]}}} : nib[3:0];
        end
      end
      OP_LLB:         ALU_Out = {Input_A[15:8], Input_B[7:0]};
      OP_LHB:         ALU_Out = {Input_B[7:0], Input_A[7:0]};
      default:        ALU_Out = Input_A + Input_B;
    endcase
  end

  assign Z_set = (ALU_Out == 16'h0000);
  assign N_set = ALU_Out[15];
  assign V_set = ovf;

endmodule

// File: rtl/wisc_mem.sv
// Word-organised 32K x 16 memory (64 KB byte space) with combinational read
// and a clocked write; used for both instruction and data storage.
module wisc_mem #(
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic [15:1] addr,
  input  logic [15:0] wdata,
  input  logic        en,
  input  logic        we,
  output logic [15:0] rdata
);

  logic [15:0] mem [0:32767];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/wisc_cpu.sv
// WISC-S25 single-cycle core: decode, register file, flags and PC update in
// one clock, with Harvard instruction/data memories.
module wisc_cpu
  import wisc_pkg::*;
#(
  parameter string IMEM_INIT = "instructions.img",
  parameter string DMEM_INIT = "data.img"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        hlt,
  output logic [15:0] pc
);

  logic [15:0] pc_d, pc_q;
  logic [2:0]  flags_d, flags_q;
  logic [15:0] regs_d [16];
  logic [15:0] regs_q [16];

  logic [15:0] pc_inst, dmem_rdata, pc_plus2, b_target, imm;
  logic [15:0] rd_data1, rd_data2, Input_B, wb_data, ALU_Out;
  logic [3:0]  reg_rs, reg_rt, reg_rd, rd1_sel, rd2_sel;
  logic [2:0]  c_codes;
  opcode_e     opcode, ALUOp;
  logic        ALUSrc, MemtoReg, RegWrite, RegSrc, MemEnable, MemWrite;
  logic        Branch, HLT, PCS, Z_en, NV_en, BR;
  logic        Z_set, N_set, V_set;

  wisc_mem #(.INIT_FILE(IMEM_INIT)) iINSTR_MEM (
    .clk(clk), .addr(pc_q[15:1]), .wdata(16'h0000), .en(1'b0), .we(1'b0), .rdata(pc_inst)
  );

  wisc_mem #(.INIT_FILE(DMEM_INIT)) iDATA_MEM (
    .clk(clk), .addr(ALU_Out[15:1]), .wdata(rd_data2), .en(MemEnable), .we(MemWrite),
    .rdata(dmem_rdata)
  );

  assign opcode  = opcode_e'(pc_inst[15:12]);
  assign reg_rd  = pc_inst[11:8];
  assign reg_rs  = pc_inst[7:4];
  assign reg_rt  = pc_inst[3:0];
  assign c_codes = pc_inst[11:9];

  always_comb begin
    ALUOp = opcode;
    {ALUSrc, MemtoReg, RegWrite, RegSrc, MemEnable, MemWrite} = 6'b000000;
    {Branch, HLT, PCS, Z_en, NV_en} = 5'b00000;
    case (opcode)
      OP_ADD, OP_SUB:          {RegWrite, Z_en, NV_en} = 3'b111;
      OP_XOR:                  {RegWrite, Z_en} = 2'b11;
      OP_SLL, OP_SRA, OP_ROR:  {RegWrite, ALUSrc, Z_en} = 3'b111;
      OP_RED, OP_PADDSB:       RegWrite = 1'b1;
      OP_LW:                   {RegWrite, ALUSrc, MemtoReg, MemEnable} = 4'b1111;
      OP_SW:                   {ALUSrc, RegSrc, MemEnable, MemWrite} = 4'b1111;
      OP_LLB, OP_LHB:          {RegWrite, ALUSrc} = 2'b11;
      OP_B, OP_BR:             Branch = 1'b1;
      OP_PCS:                  {RegWrite, PCS} = 2'b11;
      OP_HLT:                  HLT = 1'b1;
      default:                 HLT = 1'b0;
    endcase
  end

  // LLB/LHB read rd through port 1 for the merge; SW reads its data register (rt) from [11:8]
  always_comb begin
    rd1_sel  = (opcode == OP_LLB || opcode == OP_LHB) ? reg_rd : reg_rs;
    rd2_sel  = RegSrc ? reg_rd : reg_rt;
    rd_data1 = regs_q[rd1_sel];
    rd_data2 = regs_q[rd2_sel];
    case (opcode)
      OP_SLL, OP_SRA, OP_ROR: imm = {12'h000, pc_inst[3:0]};
      OP_LW, OP_SW:           imm = {{11{pc_inst[3]}}, pc_inst[3:0], 1'b0};
      default:                imm = {8'h00, pc_inst[7:0]};
    endcase
    Input_B = ALUSrc ? imm : rd_data2;
  end

  wisc_alu iALU (
    .op(ALUOp), .Input_A(rd_data1), .Input_B(Input_B),
    .ALU_Out(ALU_Out), .Z_set(Z_set), .N_set(N_set), .V_set(V_set)
  );

  always_comb begin
    pc_plus2 = pc_q + 16'd2;
    b_target = pc_plus2 + {{6{pc_inst[8]}}, pc_inst[8:0], 1'b0};
    BR       = Branch && cond_met(ccode_e'(c_codes), flags_q);
    if (HLT) begin
      pc_d = pc_q;
    end else if (BR) begin
      pc_d = (opcode == OP_BR) ? rd_data1 : b_target;
    end else begin
      pc_d = pc_plus2;
    end
  end

  always_comb begin
    wb_data = PCS ? pc_plus2 : (MemtoReg ? dmem_rdata : ALU_Out);
    regs_d  = regs_q;
    if (RegWrite && reg_rd != 4'd0) begin
      regs_d[reg_rd] = wb_data;
    end else begin
      regs_d[0] = 16'h0000;
    end
    flags_d = flags_q;
    if (Z_en) begin
      flags_d[FLAG_Z] = Z_set;
    end else begin
      flags_d[FLAG_Z] = flags_q[FLAG_Z];
    end
    if (NV_en) begin
      flags_d[FLAG_N] = N_set;
      flags_d[FLAG_V] = V_set;
    end else begin
      flags_d[FLAG_N] = flags_q[FLAG_N];
      flags_d[FLAG_V] = flags_q[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 16'h0000;
      flags_q <= 3'b000;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign hlt = HLT;
  assign pc  = pc_q;

endmodule

// File: tb/tb_wisc_cpu.sv
// Self-checking bench for wisc_cpu: a directed program plus random programs,
// each run in lockstep against an instruction-level ISA model.
module tb_wisc_cpu;

  logic        clk;
  logic        rst_n;
  logic        hlt;
  logic [15:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_imem [32768];
  logic [15:0] m_dmem [32768];
  logic [15:0] m_reg  [16];
  logic [15:0] m_pc;
  logic        m_z, m_v, m_n;
  int          sw_idx [$];

  wisc_cpu #(.IMEM_INIT(""), .DMEM_INIT("")) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sxn(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic bit m_cond(input logic [2:0] cc);
    case (cc)
      3'd0:    return !m_z;
      3'd1:    return m_z;
      3'd2:    return !m_z && !m_n;
      3'd3:    return m_n;
      3'd4:    return m_z || (!m_z && !m_n);
      3'd5:    return m_z || m_n;
      3'd6:    return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic m_write(input logic [3:0] d, input logic [15:0] v);
    if (d != 4'd0) m_reg[d] = v;
  endtask

  // ISA model: execute one instruction at m_pc
  task automatic model_step();
    logic [15:0] ins, a, b, res, nxt;
    logic [3:0]  op, d, s, t;
    int r, c, ad;
    ins = m_imem[m_pc[15:1]];
    op = ins[15:12]; d = ins[11:8]; s = ins[7:4]; t = ins[3:0];
    a = m_reg[s]; b = m_reg[t];
    nxt = m_pc + 16'd2;
    ad = (int'(a) + 2 * sxn(int'(t), 4)) & 65535;
    case (op)
      4'h0, 4'h1: begin
        r = (op == 4'h0) ? sxn(int'(a), 16) + sxn(int'(b), 16) : sxn(int'(a), 16) - sxn(int'(b), 16);
        c = clamp(r, -32768, 32767);
        res = 16'(c);
        m_v = (c != r); m_n = (c < 0); m_z = (c == 0);
        m_write(d, res);
      end
      4'h2: begin res = a ^ b; m_z = (res == 16'd0); m_write(d, res); end
      4'h3: begin
        r = sxn(int'(a[15:8]), 8) + sxn(int'(b[15:8]), 8) + sxn(int'(a[7:0]), 8) + sxn(int'(b[7:0]), 8);
        m_write(d, 16'(r));
      end
      4'h4: begin res = 16'(int'(a) << t); m_z = (res == 16'd0); m_write(d, res); end
      4'h5: begin res = 16'(sxn(int'(a), 16) >>> t); m_z = (res == 16'd0); m_write(d, res); end
      4'h6: begin
        res = 16'((int'(a) >> t) | (int'(a) << (16 - int'(t))));
        m_z = (res == 16'd0); m_write(d, res);
      end
      4'h7: begin
        c = 0;
        for (int k = 0; k < 4; k++) begin
          r = clamp(sxn((int'(a) >> (4 * k)) & 15, 4) + sxn((int'(b) >> (4 * k)) & 15, 4), -8, 7);
          c = c | ((r & 15) << (4 * k));
        end
        m_write(d, 16'(c));
      end
      4'h8: m_write(d, m_dmem[ad >> 1]);
      4'h9: begin m_dmem[ad >> 1] = m_reg[d]; sw_idx.push_back(ad >> 1); end
      4'hA: m_write(d, {m_reg[d][15:8], ins[7:0]});
      4'hB: m_write(d, {ins[7:0], m_reg[d][7:0]});
      4'hC: if (m_cond(ins[11:9])) nxt = 16'(int'(m_pc) + 2 + 2 * sxn(int'(ins[8:0]), 9));
      4'hD: if (m_cond(ins[11:9])) nxt = a;
      4'hE: m_write(d, m_pc + 16'd2);
      default: nxt = m_pc;
    endcase
    m_pc = nxt;
  endtask

  // Assert reset, load both memories into DUT and model, release at a negedge
  task automatic load_and_reset();
    logic [15:0] v;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_pc_async", pc, 16'h0000);
    for (int i = 0; i < 32768; i++) begin
      dut.iINSTR_MEM.mem[i] = m_imem[i];
      v = 16'($urandom);
      m_dmem[i] = v;
      dut.iDATA_MEM.mem[i] = v;
    end
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_pc = 16'h0000; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
    sw_idx.delete();
    @(negedge clk);
    check_eq("rst_flags", dut.flags_q, 3'b000);
    for (int i = 0; i < 16; i++) check_eq($sformatf("rst_r%0d", i), dut.regs_q[i], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input int budget);
    logic [15:0] ins;
    bit halted;
    halted = 1'b0;
    for (int cyc = 0; cyc < budget && !halted; cyc++) begin
      ins = m_imem[m_pc[15:1]];
      check_eq("pc", pc, m_pc);
      check_eq("hlt", hlt, ins[15:12] == 4'hF);
      check_eq("flags", dut.flags_q, {m_z, m_v, m_n});
      for (int i = 0; i < 16; i++) check_eq($sformatf("r%0d", i), dut.regs_q[i], m_reg[i]);
      if (ins[15:12] == 4'hF) begin
        halted = 1'b1;
      end else begin
        model_step();
        @(negedge clk);
      end
    end
    if (halted) begin
      repeat (2) begin
        @(negedge clk);
        check_eq("hlt_pc_frozen", pc, m_pc);
        check_eq("hlt_held", hlt, 1'b1);
      end
    end
    foreach (sw_idx[i]) check_eq("dmem", dut.iDATA_MEM.mem[sw_idx[i]], m_dmem[sw_idx[i]]);
  endtask

  task automatic place(input logic [15:0] addr, input logic [15:0] word);
    m_imem[addr[15:1]] = word;
  endtask

  initial begin
    logic [3:0]  op;
    logic [8:0]  off9;
    logic [15:0] word;
    int          r;
    rst_n = 1'b0;

    // Directed program exercising the headline behaviours
    for (int i = 0; i < 32768; i++) m_imem[i] = 16'hF000;
    place(16'h00, 16'hA1FF); place(16'h02, 16'hB17F); place(16'h04, 16'hA201);
    place(16'h06, 16'h0312); place(16'h08, 16'hA410); place(16'h0A, 16'h9341);
    place(16'h0C, 16'h8541); place(16'h0E, 16'h1611); place(16'h10, 16'hC010);
    place(16'h12, 16'hCE06); place(16'h20, 16'hC202); place(16'h26, 16'hCE04);
    place(16'h30, 16'hE700); place(16'h32, 16'hA838); place(16'h34, 16'hDE80);
    place(16'h38, 16'hAA77); place(16'h3A, 16'hBA77); place(16'h3C, 16'hAB11);
    place(16'h3E, 16'hBB11); place(16'h40, 16'h7CAB); place(16'h42, 16'hAD01);
    place(16'h44, 16'hBD80); place(16'h46, 16'h6ED1); place(16'h48, 16'hF000);
    load_and_reset();
    run_prog(200);
    check_eq("sat_add_r3", dut.regs_q[3], 16'h7FFF);
    check_eq("lw_r5", dut.regs_q[5], 16'h7FFF);
    check_eq("sw_dmem12", dut.iDATA_MEM.mem[9], 16'h7FFF);
    check_eq("sub_r6", dut.regs_q[6], 16'h0000);
    check_eq("pcs_r7", dut.regs_q[7], 16'h0032);
    check_eq("paddsb_r12", dut.regs_q[12], 16'h7777);
    check_eq("ror_r14", dut.regs_q[14], 16'hC000);
    check_eq("halt_pc", pc, 16'h0048);

    // Random programs; everything outside the program is HLT
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 32768; i++) m_imem[i] = 16'hF000;
      for (int i = 0; i < 48; i++) begin
        r = $urandom_range(0, 19);
        op = (r >= 18) ? 4'hB : ((r >= 15) ? 4'hA : 4'(r));
        if (i == 0) op = 4'hA;
        word = {op, 12'($urandom)};
        if (op == 4'hC) begin
          off9 = 9'($urandom_range(0, 10));
          off9 = off9 - 9'd2;
          word[8:0] = off9;
        end
        m_imem[i] = word;
      end
      load_and_reset();
      run_prog(300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
